// File: rtl/rs232_rx.sv
// 8N1 serial receiver: synchronises the RXD pin, samples each bit at mid-bit and
// holds the last good byte in a one-deep register with a valid/ack handshake.
module rs232_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       UART_RXD,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_n;
  logic          rxd_m, rxd_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic [7:0]    rx_data_n;
  logic          rx_valid_n, frame_err_n, overrun_n;

  // Both synchroniser flops reset high so reset release never looks like a start bit.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= UART_RXD;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    idx_n       = idx;
    sh_n        = sh;
    rx_data_n   = rx_data;
    rx_valid_n  = rx_valid;
    frame_err_n = 1'b0;
    overrun_n   = overrun;

    // An ack is applied first so a byte landing in the same cycle still wins.
    if (rx_valid && rx_ack) begin
      rx_valid_n = 1'b0;
      overrun_n  = 1'b0;
    end

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxd_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          sh_n[idx] = rxd_s;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rxd_s) begin
            rx_data_n  = sh;
            rx_valid_n = 1'b1;
            if (rx_valid && !rx_ack) overrun_n = 1'b1;
            state_n    = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = BREAK;
          end
        end
      end
      // A held-low line must rise before another start bit is accepted.
      BREAK: begin
        cnt_n = '0;
        if (rxd_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rs232_rx.sv
// Directed plus randomized bench for rs232_rx; expected bytes and flags come from a
// transaction-level model of the handshake, and timing from the bit-period arithmetic.
module tb_rs232_rx;

  localparam int N = 64;
  localparam int H = N / 2;
  localparam int LOAD_IDX = H + 9 * N + 3;

  logic       CLOCK_50;
  logic       RST;
  logic       UART_RXD;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int fe_count = 0;
  int valid_rises = 0;
  int busy_cycles = 0;
  logic valid_q = 1'b0;

  logic busy_at  [0:4095];
  logic valid_at [0:4095];

  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_ovr;

  rs232_rx #(.CLKS_PER_BIT(N)) dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .UART_RXD (UART_RXD),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    fe_count    += int'(frame_err);
    busy_cycles += int'(busy);
    if (rx_valid && !valid_q) valid_rises++;
    valid_q = rx_valid;
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Iteration c drives the line for edge P+c and records outputs as left by edge P+c-1.
  task automatic applyStimulus(input logic [7:0] b, input int len, input logic stop_bit,
                               input int hold_low, input int ack_at);
    int total;
    int bitn;
    total = 10 * len + hold_low;
    for (int c = 0; c <= total; c++) begin
      @(negedge CLOCK_50);
      busy_at[c]  = busy;
      valid_at[c] = rx_valid;
      bitn = c / len;
      if (c == total)          UART_RXD = 1'b1;
      else if (c >= 10 * len)  UART_RXD = 1'b0;
      else if (bitn == 0)      UART_RXD = 1'b0;
      else if (bitn <= 8)      UART_RXD = b[bitn-1];
      else                     UART_RXD = stop_bit;
      rx_ack = (c == ack_at);
    end
    @(negedge CLOCK_50);
    rx_ack = 1'b0;
  endtask

  task automatic pulseAck();
    @(negedge CLOCK_50);
    rx_ack = 1'b1;
    @(negedge CLOCK_50);
    rx_ack = 1'b0;
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end
  endtask

  task automatic modelByte(input logic [7:0] b, input logic ack_same);
    if (exp_valid && !ack_same) exp_ovr = 1'b1;
    else if (ack_same)          exp_ovr = 1'b0;
    exp_valid = 1'b1;
    exp_data  = b;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_data"},  rx_data, exp_data);
    checkOutput({tag, "_valid"}, 8'(rx_valid), 8'(exp_valid));
    checkOutput({tag, "_ovr"},   8'(overrun),  8'(exp_ovr));
  endtask

  initial begin
    int fe0, vr0, bc0;
    logic [7:0] rb;
    int rlen;

    RST = 1'b1;
    UART_RXD = 1'b1;
    rx_ack = 1'b0;
    exp_data = 8'h00;
    exp_valid = 1'b0;
    exp_ovr = 1'b0;

    repeat (5) @(negedge CLOCK_50);
    checkOutput("rst_data", rx_data, 8'h00);
    checkOutput("rst_valid_busy", {6'b0, rx_valid, busy}, 8'h00);
    checkOutput("rst_fe_ovr", {6'b0, frame_err, overrun}, 8'h00);
    RST = 1'b0;
    repeat (10) @(negedge CLOCK_50);

    // Single byte with exact latency checks
    applyStimulus(8'hA5, N, 1'b1, 0, -1);
    modelByte(8'hA5, 1'b0);
    checkOutput("a5_busy_pre",  8'(busy_at[2]), 8'h00);
    checkOutput("a5_busy_t0",   8'(busy_at[3]), 8'h01);
    checkOutput("a5_valid_pre", 8'(valid_at[LOAD_IDX-1]), 8'h00);
    checkOutput("a5_valid_at",  8'(valid_at[LOAD_IDX]), 8'h01);
    repeat (20) @(negedge CLOCK_50);
    checkModel("a5");
    pulseAck();
    checkOutput("a5_ack_clear", 8'(rx_valid), 8'h00);

    // Short glitch must not start a frame
    #1;
    fe0 = fe_count; vr0 = valid_rises; bc0 = busy_cycles;
    @(negedge CLOCK_50);
    UART_RXD = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    UART_RXD = 1'b1;
    repeat (3 * N) @(negedge CLOCK_50);
    #1;
    checkOutput("glitch_busy_seen", 8'(busy_cycles - bc0 > 0), 8'h01);
    checkOutput("glitch_busy_len",  8'(busy_cycles - bc0 <= H + 2), 8'h01);
    checkOutput("glitch_no_valid",  8'(valid_rises - vr0), 8'h00);
    checkOutput("glitch_no_fe",     8'(fe_count - fe0), 8'h00);

    // Framing error followed by a held-low line
    fe0 = fe_count; vr0 = valid_rises;
    applyStimulus(8'h3C, N, 1'b0, 3 * N, -1);
    #1;
    checkOutput("fe_pulses", 8'(fe_count - fe0), 8'h01);
    checkOutput("fe_no_valid", 8'(valid_rises - vr0), 8'h00);
    checkOutput("fe_busy_low", 8'(busy_at[10 * N + 3 * N]), 8'h01);
    checkOutput("fe_busy_hold", 8'(busy), 8'h01);
    repeat (2) @(negedge CLOCK_50);
    checkOutput("fe_busy_release", 8'(busy), 8'h00);
    checkOutput("fe_data_kept", rx_data, exp_data);
    applyStimulus(8'h5A, N, 1'b1, 0, -1);
    modelByte(8'h5A, 1'b0);
    checkModel("after_fe");
    pulseAck();

    // Overrun: two frames without ack, then one ack clears both flags
    applyStimulus(8'h11, N, 1'b1, 0, -1);
    modelByte(8'h11, 1'b0);
    applyStimulus(8'h22, N, 1'b1, 0, -1);
    modelByte(8'h22, 1'b0);
    checkModel("overrun");
    pulseAck();
    checkModel("overrun_ack");

    // Ack on the load edge of a new byte while overrun is set
    applyStimulus(8'h33, N, 1'b1, 0, -1);
    modelByte(8'h33, 1'b0);
    applyStimulus(8'h44, N, 1'b1, 0, -1);
    modelByte(8'h44, 1'b0);
    checkOutput("coll_pre_ovr", 8'(overrun), 8'h01);
    applyStimulus(8'h7E, N, 1'b1, 0, LOAD_IDX - 1);
    modelByte(8'h7E, 1'b1);
    checkModel("collision");
    pulseAck();

    // Randomized bytes with +-1.5 % bit period and random acks
    for (int i = 0; i < 5; i++) begin
      rb = 8'($urandom);
      rlen = N - 1 + int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) pulseAck();
      applyStimulus(rb, rlen, 1'b1, 0, -1);
      modelByte(rb, 1'b0);
      checkModel($sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of a frame
    applyStimulus(8'hC3, N, 1'b1, 0, -1);
    applyStimulus(8'h96, N, 1'b1, 0, -1);
    @(negedge CLOCK_50);
    UART_RXD = 1'b0;
    repeat (3 * N) @(negedge CLOCK_50);
    checkOutput("mid_busy", 8'(busy), 8'h01);
    RST = 1'b1;
    #1;
    checkOutput("mid_rst_data", rx_data, 8'h00);
    checkOutput("mid_rst_flags", {4'b0, rx_valid, frame_err, overrun, busy}, 8'h00);
    UART_RXD = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    RST = 1'b0;
    #1;
    vr0 = valid_rises; bc0 = busy_cycles; fe0 = fe_count;
    repeat (10 * N) @(negedge CLOCK_50);
    #1;
    checkOutput("post_rst_quiet", 8'(busy_cycles - bc0 + valid_rises - vr0 + fe_count - fe0), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
